// File: rtl/timer_controller.sv
// Sequencing controller for an N-bit up-counter: start/stop/pause, programmable terminal
// count, clock prescaler, one-shot or periodic reload, done pulse and saturating lap count.
module timer_controller #(
  parameter int N = 8,
  parameter int P = 4,
  parameter int L = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_stop,
  input  logic         i_pause,
  input  logic         i_periodic,
  input  logic [N-1:0] i_load_val,
  input  logic [P-1:0] i_presc,
  output logic [N-1:0] o_cnt,
  output logic         o_tick,
  output logic         o_busy,
  output logic         o_done,
  output logic [L-1:0] o_laps,
  output logic [1:0]   o_state
);

  // Control handshake: i_start/i_stop are single-cycle strobes sampled on the rising
  // edge (stop wins over start, start wins over pause); i_pause is a level.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t       r_state;
  logic [N-1:0] r_cnt;
  logic [N-1:0] r_limit;
  logic [P-1:0] r_presc_cnt;
  logic [P-1:0] r_presc;
  logic         r_periodic;
  logic [L-1:0] r_laps;
  logic         r_done;

  logic w_tick;
  logic w_last;
  logic w_start_ok;

  assign w_tick     = (r_state == S_RUN) && (r_presc_cnt == r_presc);
  assign w_last     = (r_cnt == r_limit - N'(1));
  assign w_start_ok = i_start && (i_load_val != '0);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_limit     <= '0;
      r_presc_cnt <= '0;
      r_presc     <= '0;
      r_periodic  <= 1'b0;
      r_laps      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_stop) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_presc_cnt <= '0;
        r_laps      <= '0;
      end else if (w_start_ok) begin
        r_state     <= S_RUN;
        r_cnt       <= '0;
        r_presc_cnt <= '0;
        r_laps      <= '0;
        r_limit     <= i_load_val;
        r_presc     <= i_presc;
        r_periodic  <= i_periodic;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_tick) begin
              r_presc_cnt <= '0;
              if (w_last) begin
                r_done <= 1'b1;
                if (r_periodic) begin
                  r_cnt <= '0;
                  if (r_laps != '1) r_laps <= r_laps + L'(1);
                end else begin
                  r_state <= S_DONE;
                end
              end else begin
                r_cnt <= r_cnt + N'(1);
              end
            end else begin
              r_presc_cnt <= r_presc_cnt + P'(1);
            end
            // The RUN cycle that sees pause still counts; freezing starts in HOLD, so the
            // HOLD->RUN exit cycle makes each paused cycle cost exactly one clock.
            if (i_pause && !(w_tick && w_last && !r_periodic)) r_state <= S_HOLD;
          end
          S_HOLD: if (!i_pause) r_state <= S_RUN;
          default: ;
        endcase
      end
    end
  end

  assign o_cnt   = r_cnt;
  assign o_tick  = w_tick;
  assign o_busy  = (r_state == S_RUN) || (r_state == S_HOLD);
  assign o_done  = r_done;
  assign o_laps  = r_laps;
  assign o_state = r_state;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller (N=4, P=2, L=8): inputs driven and outputs
// sampled on the falling edge, expected values computed by hand.
module tb_timer_controller;

  localparam int N = 4;
  localparam int P = 2;
  localparam int L = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         pause;
  logic         periodic;
  logic [N-1:0] load_val;
  logic [P-1:0] presc;
  logic [N-1:0] cnt;
  logic         tick;
  logic         busy;
  logic         done;
  logic [L-1:0] laps;
  logic [1:0]   state;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;

  timer_controller #(.N(N), .P(P), .L(L)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_stop     (stop),
    .i_pause    (pause),
    .i_periodic (periodic),
    .i_load_val (load_val),
    .i_presc    (presc),
    .o_cnt      (cnt),
    .o_tick     (tick),
    .o_busy     (busy),
    .o_done     (done),
    .o_laps     (laps),
    .o_state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the falling edge just after the accepted start edge.
  task automatic pulse_start(input logic [N-1:0] lv, input logic [P-1:0] ps, input logic per);
    start    = 1'b1;
    load_val = lv;
    presc    = ps;
    periodic = per;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    periodic = 1'b0; load_val = '0; presc = '0;
    #1;
    chk("por_state", state, 2'b00);
    chk("por_cnt", cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Periodic limit 2 to build up laps, then async reset with start held high.
    pulse_start(4'd2, 2'd0, 1'b1);
    step(6);
    chk("pre_rst_laps", laps, 3);
    chk("pre_rst_done", done, 1);
    start = 1'b1; load_val = 4'd5; rst = 1'b1;
    #1;
    chk("rst_state", state, 2'b00);
    chk("rst_cnt", cnt, 0);
    chk("rst_laps", laps, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;

    // One-shot, limit 5, no prescale.
    pulse_start(4'd5, 2'd0, 1'b0);
    chk("os_state_run", state, 2'b01);
    chk("os_cnt0", cnt, 0);
    chk("os_busy", busy, 1);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      chk("os_cnt_step", cnt, i);
      chk("os_done_low", done, 0);
    end
    step(1);
    chk("os_done_pulse", done, 1);
    chk("os_state_done", state, 2'b11);
    chk("os_cnt_hold", cnt, 4);
    chk("os_busy_low", busy, 0);
    step(1);
    chk("os_done_one_cycle", done, 0);
    chk("os_cnt_hold2", cnt, 4);

    // Periodic, limit 3, prescale 2: period 9 clocks.
    pulse_start(4'd3, 2'd2, 1'b1);
    step(2);
    chk("per_cnt_e2", cnt, 0);
    step(1);
    chk("per_cnt_e3", cnt, 1);
    step(5);
    chk("per_cnt_e8", cnt, 2);
    chk("per_tick_e8", tick, 1);
    chk("per_done_e8", done, 0);
    step(1);
    chk("per_done1", done, 1);
    chk("per_cnt_wrap", cnt, 0);
    chk("per_laps1", laps, 1);
    for (int lap = 2; lap <= 3; lap++) begin
      step(8);
      chk("per_done_gap", done, 0);
      chk("per_laps_hold", laps, lap - 1);
      step(1);
      chk("per_done_n", done, 1);
      chk("per_laps_n", laps, lap);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("per_stop_state", state, 2'b00);
    chk("per_stop_cnt", cnt, 0);
    chk("per_stop_laps", laps, 0);
    chk("per_stop_done", done, 0);

    // One-shot limit 4 prescale 1 (8 clocks) with 4 paused cycles: done at 12.
    pulse_start(4'd4, 2'd1, 1'b0);
    step(3);
    chk("pz_cnt_e3", cnt, 1);
    pause = 1'b1;
    step(1);
    chk("pz_state_hold", state, 2'b10);
    chk("pz_cnt_e4", cnt, 2);
    chk("pz_tick_low", tick, 0);
    chk("pz_busy", busy, 1);
    step(3);
    chk("pz_cnt_frozen", cnt, 2);
    chk("pz_state_still", state, 2'b10);
    pause = 1'b0;
    cyc = 7;
    while (!done && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("pz_done_latency", cyc, 12);
    chk("pz_state_done", state, 2'b11);
    chk("pz_cnt_final", cnt, 3);

    // Stop and start together while running; then start with load_val 0.
    pulse_start(4'd3, 2'd0, 1'b1);
    step(1);
    chk("ss_cnt1", cnt, 1);
    stop = 1'b1; start = 1'b1; load_val = 4'd5;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("ss_state", state, 2'b00);
    chk("ss_cnt", cnt, 0);
    chk("ss_done", done, 0);
    step(3);
    chk("ss_no_done", done, 0);
    chk("ss_still_idle", state, 2'b00);
    pulse_start(4'd0, 2'd0, 1'b0);
    chk("z_state_idle", state, 2'b00);
    chk("z_busy", busy, 0);

    // Async reset mid-run, then restart from zero.
    pulse_start(4'd5, 2'd0, 1'b1);
    step(2);
    chk("ar_cnt2", cnt, 2);
    rst = 1'b1;
    #1;
    chk("ar_cnt", cnt, 0);
    chk("ar_state", state, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    pulse_start(4'd5, 2'd0, 1'b1);
    chk("ar_restart_state", state, 2'b01);
    chk("ar_restart_cnt0", cnt, 0);
    step(3);
    chk("ar_restart_cnt3", cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
